// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: default widths and FSM state codes.
package loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int WORD_W_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD_I = 3'd1;
    localparam state_t ST_LOAD_D = 3'd2;
    localparam state_t ST_START  = 3'd3;
    localparam state_t ST_RUN    = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready word stream carrying the program image into the loader.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader_word_counter.sv
// Word address counter shared by the instruction and data load phases.
module word_counter
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W:0]   limit,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    // Clear wins over increment so the phase-change accept restarts at address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Flagging limit-1 lets the exit happen on the last word, so count never wraps.
    assign last = ({1'b0, count} == (limit - 1'b1));

endmodule

// File: rtl/program_loader.sv
// Streams an image into instruction/data memory, then releases and monitors the core.
//
// state   | meaning
// IDLE    | waiting for load_start, core held in reset
// LOAD_I  | accepting instruction words into imem
// LOAD_D  | accepting data words into dmem
// START   | one-cycle core release pulse
// RUN     | core running, waiting for proc_signal
// DONE    | core finished, final_pc held, reload allowed
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   instr_count,
    input  logic [ADDR_W:0]   data_count,
    program_loader_if.slave   strm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic              proc_rst,
    output logic              proc_start,
    output logic [WORD_W-1:0] final_pc,
    input  logic              proc_signal,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [ADDR_W:0] clamp_cnt(input logic [ADDR_W:0] c);
        return (c > DEPTH) ? DEPTH : c;
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   instr_lim_q;
    logic [ADDR_W:0]   data_lim_q;
    logic [ADDR_W:0]   instr_cl;
    logic [ADDR_W:0]   data_cl;
    logic [ADDR_W:0]   cur_lim;
    logic [ADDR_W-1:0] wcnt;
    logic              wlast;
    logic              ctr_clear;
    logic              accept;
    logic              start_ok;
    logic              in_ready_q;

    assign instr_cl      = clamp_cnt(instr_count);
    assign data_cl       = clamp_cnt(data_count);
    assign accept        = strm.in_valid & in_ready_q;
    assign start_ok      = load_start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign cur_lim       = (state_q == ST_LOAD_D) ? data_lim_q : instr_lim_q;
    assign strm.in_ready = in_ready_q;

    word_counter #(.ADDR_W(ADDR_W)) u_word_counter (
        .clk   (clk),
        .reset (reset),
        .clear (ctr_clear),
        .inc   (accept),
        .limit (cur_lim),
        .count (wcnt),
        .last  (wlast)
    );

    // Next-state decode; the counter is cleared on every phase entry.
    always_comb begin
        state_d   = state_q;
        ctr_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    ctr_clear = 1'b1;
                    if (instr_cl != '0)     state_d = ST_LOAD_I;
                    else if (data_cl != '0) state_d = ST_LOAD_D;
                    else                    state_d = ST_START;
                end
            end
            ST_LOAD_I: begin
                if (accept && wlast) begin
                    ctr_clear = 1'b1;
                    state_d   = (data_lim_q != '0) ? ST_LOAD_D : ST_START;
                end
            end
            ST_LOAD_D: begin
                if (accept && wlast) begin
                    ctr_clear = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (proc_signal) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State plus status outputs, all registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            instr_lim_q <= '0;
            data_lim_q  <= '0;
            final_pc    <= '0;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            proc_rst    <= 1'b1;
            proc_start  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_LOAD_I) || (state_d == ST_LOAD_D);
            busy       <= (state_d == ST_LOAD_I) || (state_d == ST_LOAD_D) ||
                          (state_d == ST_START)  || (state_d == ST_RUN);
            done       <= (state_d == ST_DONE);
            proc_rst   <= (state_d == ST_IDLE)   || (state_d == ST_LOAD_I) ||
                          (state_d == ST_LOAD_D) || (state_d == ST_START);
            proc_start <= (state_d == ST_START);
            if (start_ok) begin
                instr_lim_q <= instr_cl;
                data_lim_q  <= data_cl;
                final_pc    <= {{(WORD_W-ADDR_W-1){1'b0}}, instr_cl};
            end
        end
    end

    // Memory write ports, one cycle behind the accept; addr/data hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            imem_we <= accept && (state_q == ST_LOAD_I);
            dmem_we <= accept && (state_q == ST_LOAD_D);
            if (accept && (state_q == ST_LOAD_I)) begin
                imem_addr  <= wcnt;
                imem_wdata <= strm.in_data;
            end
            if (accept && (state_q == ST_LOAD_D)) begin
                dmem_addr  <= wcnt;
                dmem_wdata <= strm.in_data;
            end
        end
    end

endmodule
